mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// N-port request arbiter for the LC-3b memory subsystem: serialises per-port
// read/write requests onto one downstream port and routes each response back.
module mem_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int RR_MODE    = 1,
    localparam int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_wmask,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [MASK_WIDTH-1:0]            mem_wmask,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic                             mem_resp,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             busy,
    output logic [ID_W-1:0]                  grant_id
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [ID_W:0] NP = (ID_W+1)'(NUM_PORTS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     w_grant_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_rr_nxt;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any;
    logic [ID_W-1:0]      w_idx;
    logic [ID_W-1:0]      w_winner;
    logic                 w_found;

    logic [MASK_WIDTH-1:0] w_mask_arr [NUM_PORTS];
    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_PORTS];

    logic                  w_g_read;
    logic                  w_g_write;
    logic [MASK_WIDTH-1:0] w_g_mask;
    logic [ADDR_WIDTH-1:0] w_g_addr;
    logic [DATA_WIDTH-1:0] w_g_data;

    // Port index increment, wrapping modulo NUM_PORTS (which need not be a power of two).
    function automatic logic [ID_W-1:0] f_wrap_inc(input logic [ID_W-1:0] a);
        logic [ID_W:0] s;
        s = {1'b0, a} + (ID_W+1)'(1);
        if (s >= NP) begin
            return '0;
        end
        return s[ID_W-1:0];
    endfunction

    genvar g;
    for (g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_mask_arr[g] = req_wmask[g*MASK_WIDTH +: MASK_WIDTH];
        assign w_addr_arr[g] = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_req = req_read | req_write;
    assign w_any = |w_req;

    // Scan from the start point; fixed priority always starts at port 0.
    always_comb begin
        w_idx    = (RR_MODE != 0) ? r_rr_ptr : '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && w_req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
            w_idx = f_wrap_inc(w_idx);
        end
    end

    assign w_g_read  = req_read[r_grant_id];
    assign w_g_write = req_write[r_grant_id];
    assign w_g_mask  = w_mask_arr[r_grant_id];
    assign w_g_addr  = w_addr_arr[r_grant_id];
    assign w_g_data  = w_data_arr[r_grant_id];

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = '0;
        mem_address = w_g_addr;
        mem_wdata   = w_g_data;
        req_resp    = '0;
        req_rdata   = mem_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_any && w_found) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = w_winner;
                end
            end
            S_BUSY: begin
                // A simultaneous read+write request is treated as a write.
                mem_read  = w_g_read & ~w_g_write;
                mem_write = w_g_write;
                mem_wmask = w_g_mask;
                if (mem_resp) begin
                    req_resp[r_grant_id] = 1'b1;
                    w_state_nxt          = S_IDLE;
                    if (RR_MODE != 0) begin
                        w_rr_nxt = f_wrap_inc(r_grant_id);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
        end
    end

    assign busy     = (r_state == S_BUSY);
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 4-port round-robin arbiter and a 4-port fixed-priority
// arbiter driven by the same requesters and memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [7:0]  wmask;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    logic [3:0]  rr_resp,  fp_resp;
    logic [15:0] rr_rdata, fp_rdata;
    logic        rr_mrd,   fp_mrd;
    logic        rr_mwr,   fp_mwr;
    logic [1:0]  rr_mwmask, fp_mwmask;
    logic [15:0] rr_maddr, fp_maddr;
    logic [15:0] rr_mwdata, fp_mwdata;
    logic        rr_busy,  fp_busy;
    logic [1:0]  rr_gid,   fp_gid;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr [4];
    logic [3:0]  exp_resp;
    int          exp_g;

    mem_port_arbiter #(
        .NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .RR_MODE(1)
    ) dut_rr (
        .clk(clk), .reset(reset),
        .req_read(rd), .req_write(wr), .req_wmask(wmask),
        .req_address(addr), .req_wdata(wdata),
        .req_resp(rr_resp), .req_rdata(rr_rdata),
        .mem_read(rr_mrd), .mem_write(rr_mwr), .mem_wmask(rr_mwmask),
        .mem_address(rr_maddr), .mem_wdata(rr_mwdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .busy(rr_busy), .grant_id(rr_gid)
    );

    mem_port_arbiter #(
        .NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .RR_MODE(0)
    ) dut_fp (
        .clk(clk), .reset(reset),
        .req_read(rd), .req_write(wr), .req_wmask(wmask),
        .req_address(addr), .req_wdata(wdata),
        .req_resp(fp_resp), .req_rdata(fp_rdata),
        .mem_read(fp_mrd), .mem_write(fp_mwr), .mem_wmask(fp_mwmask),
        .mem_address(fp_maddr), .mem_wdata(fp_mwdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .busy(fp_busy), .grant_id(fp_gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        exp_addr[0] = 16'h0040;
        exp_addr[1] = 16'h1234;
        exp_addr[2] = 16'h2222;
        exp_addr[3] = 16'h3333;
        reset     = 1'b1;
        rd        = 4'b0000;
        wr        = 4'b0000;
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
        wmask     = 8'b0000_0001;
        addr      = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        wdata     = {48'h0, 16'hA5A5};
        cyc();
        cyc();
        chk("rst_rr", {rr_busy, rr_gid, rr_mrd, rr_mwr, rr_mwmask, rr_resp}, 32'h0);
        chk("rst_fp", {fp_busy, fp_gid, fp_mrd, fp_mwr, fp_mwmask, fp_resp}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_rr", {rr_busy, rr_mrd, rr_mwr, rr_resp}, 32'h0);
            chk("idle_fp", {fp_busy, fp_mrd, fp_mwr, fp_resp}, 32'h0);
        end

        // Single read from port 1, memory answers three cycles after the strobe.
        rd = 4'b0010;
        #1;
        chk("rd1_no_strobe_yet", {rr_busy, rr_mrd}, 32'h0);
        cyc();
        chk("rd1_strobe", {rr_busy, rr_gid, rr_mrd, rr_mwr}, {28'h0, 1'b1, 2'd1, 1'b1, 1'b0});
        chk("rd1_addr", rr_maddr, 32'h1234);
        chk("rd1_fp_gid", fp_gid, 32'd1);
        cyc();
        chk("rd1_wait1", {rr_busy, rr_resp}, {27'h0, 1'b1, 4'b0000});
        cyc();
        chk("rd1_wait2", {rr_busy, rr_resp}, {27'h0, 1'b1, 4'b0000});
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        chk("rd1_resp", rr_resp, 32'b0010);
        chk("rd1_rdata", rr_rdata, 32'hBEEF);
        chk("rd1_fp_resp", fp_resp, 32'b0010);
        cyc();
        mem_resp = 1'b0;
        rd       = 4'b0000;
        #1;
        chk("rd1_done", {rr_busy, rr_mrd, rr_resp, fp_busy}, 32'h0);

        // All four ports requesting continuously from a fresh pointer.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rd    = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_g = n % 4;
            cyc();
            chk("all_rr_gid", rr_gid, exp_g);
            chk("all_rr_strobe", {rr_busy, rr_mrd, rr_maddr}, {15'h0, 1'b1, 1'b1, exp_addr[exp_g]});
            chk("all_fp_gid", fp_gid, 32'd0);
            mem_resp = 1'b1;
            #1;
            exp_resp = 4'b0001 << exp_g;
            chk("all_rr_resp", rr_resp, exp_resp);
            chk("all_fp_resp", fp_resp, 32'b0001);
            cyc();
            mem_resp = 1'b0;
            #1;
            chk("all_gap", {rr_busy, rr_mrd, rr_resp, fp_busy, fp_resp}, 32'h0);
        end

        // Ports 0 and 2: fixed priority always picks 0, round-robin alternates from pointer 1.
        rd = 4'b0101;
        for (int n = 0; n < 3; n++) begin
            exp_g = (n % 2 == 0) ? 2 : 0;
            cyc();
            chk("p02_fp_gid", fp_gid, 32'd0);
            chk("p02_rr_gid", rr_gid, exp_g);
            chk("p02_fp_addr", fp_maddr, 32'h0040);
            mem_resp = 1'b1;
            #1;
            chk("p02_fp_resp", fp_resp, 32'b0001);
            cyc();
            mem_resp = 1'b0;
            #1;
            chk("p02_gap", {rr_busy, fp_busy}, 32'h0);
        end

        // Port 0 write (read also asserted, so write wins) against a port 1 read.
        rd = 4'b0011;
        wr = 4'b0001;
        cyc();
        chk("wr0_rr_gid", rr_gid, 32'd0);
        chk("wr0_strobes", {rr_mrd, rr_mwr, rr_mwmask}, 32'b0101);
        chk("wr0_addr", rr_maddr, 32'h0040);
        chk("wr0_wdata", rr_mwdata, 32'hA5A5);
        chk("wr0_fp", {fp_gid, fp_mrd, fp_mwr, fp_mwmask}, 32'b00_0_1_01);
        cyc();
        chk("wr0_no_ack", {rr_busy, rr_resp, fp_resp}, {23'h0, 1'b1, 8'h00});
        mem_resp = 1'b1;
        #1;
        chk("wr0_resp", {rr_resp, fp_resp}, 32'b0001_0001);
        cyc();
        mem_resp = 1'b0;
        rd       = 4'b0010;
        wr       = 4'b0000;
        #1;
        chk("wr0_gap", {rr_busy, rr_mwr, fp_busy}, 32'h0);
        cyc();
        chk("rd1b_gid", {rr_gid, fp_gid}, 32'b01_01);
        chk("rd1b_strobes", {rr_mrd, rr_mwr, rr_maddr}, {14'h0, 1'b1, 1'b0, 16'h1234});
        mem_resp  = 1'b1;
        mem_rdata = 16'h5A5A;
        #1;
        chk("rd1b_resp", {rr_resp, fp_resp}, 32'b0010_0010);
        chk("rd1b_rdata", rr_rdata, 32'h5A5A);
        cyc();
        mem_resp = 1'b0;
        rd       = 4'b1010;
        #1;
        chk("rd1b_gap", {rr_busy, fp_busy}, 32'h0);

        // Reset two cycles into a transaction; the late memory response must be ignored.
        cyc();
        chk("rst_mid_gid", {rr_busy, rr_gid}, 32'b1_11);
        cyc();
        chk("rst_mid_busy2", {rr_busy, rr_mrd}, 32'b11);
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        chk("rst_mid_rr", {rr_busy, rr_gid, rr_mrd, rr_mwr, rr_mwmask, rr_resp}, 32'h0);
        chk("rst_mid_fp", {fp_busy, fp_gid, fp_mrd, fp_mwr, fp_mwmask, fp_resp}, 32'h0);
        cyc();
        mem_resp = 1'b0;
        #1;
        chk("post_rst_gid", {rr_busy, rr_gid, fp_gid}, 32'b1_01_01);
        chk("post_rst_strobe", {rr_mrd, rr_maddr}, {15'h0, 1'b1, 16'h1234});
        mem_resp = 1'b1;
        #1;
        chk("post_rst_resp", rr_resp, 32'b0010);
        cyc();
        mem_resp = 1'b0;
        rd       = 4'b0000;
        #1;
        chk("post_rst_gap", {rr_busy, fp_busy}, 32'h0);
        cyc();
        chk("final_idle", {rr_busy, rr_mrd, fp_busy, fp_mrd}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
